// File: rtl/dm_hart_sequencer_pkg.sv
// Shared debug-module definitions: memory map constants, hart sequencer
// state encoding and the abstract-command error codes.
package dm_hart_sequencer_pkg;

  localparam int unsigned DataAddr    = 32'h0000_0380;
  localparam int unsigned DataCount   = 2;
  localparam int unsigned ProgBufSize = 8;

  typedef enum logic [2:0] {
    RUNNING  = 3'd0,
    HALTING  = 3'd1,
    HALTED   = 3'd2,
    CMD_GO   = 3'd3,
    CMD_EXEC = 3'd4,
    RESUME   = 3'd5
  } hart_state_e;

  typedef enum logic [2:0] {
    CmdErrNone       = 3'd0,
    CmdErrBusy       = 3'd1,
    CmdErrException  = 3'd3,
    CmdErrHaltResume = 3'd4
  } cmderr_e;

endpackage

// File: rtl/dm_hart_sequencer.sv
// Debug-module sequencer for a single hart: tracks halt/resume state, drives
// the go/resume flags polled by the hart, runs abstract commands and keeps
// the sticky cmderr / resumeack status. All outputs are registered and
// reflect the state entered on the same clock edge.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   RUNNING  | hart executing normally
//   HALTING  | debug request raised, waiting for the hart's halted write
//   HALTED   | hart parked in the debug loop, accepting commands/resume
//   CMD_GO   | go flag raised, waiting for the hart's going write
//   CMD_EXEC | hart executing the command, waiting for halted/exception
//   RESUME   | resume flag raised, waiting for the hart's resuming write
module dm_hart_sequencer
  import dm_hart_sequencer_pkg::*;
#(
  parameter int unsigned HartId      = 0,
  parameter int unsigned HartIdWidth = 10,
  parameter int unsigned BusWidth    = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                haltreq_i,
  input  logic                resumereq_i,
  input  logic                cmd_valid_i,
  input  logic                cmderr_clear_i,
  input  logic                wr_halted_en_i,
  input  logic                wr_going_en_i,
  input  logic                wr_resuming_en_i,
  input  logic                wr_exception_en_i,
  input  logic [BusWidth-1:0] wdata_i,
  output logic                debug_req_o,
  output logic                flag_go_o,
  output logic                flag_resume_o,
  output logic                halted_o,
  output logic                resumeack_o,
  output logic                cmd_busy_o,
  output logic                cmd_done_o,
  output logic [2:0]          cmd_err_o
);

  hart_state_e r_state;
  hart_state_e w_state_nxt;

  logic       w_id_match;
  logic       w_halted_vld;
  logic       w_going_vld;
  logic       w_resuming_vld;
  logic       w_exception_vld;
  logic       w_unused_wdata;

  logic       w_cmd_done_nxt;
  logic       w_ack_set;
  logic       w_ack_clr;
  logic       w_err_new;
  cmderr_e    w_err_val;

  logic       w_debug_req_nxt;
  logic       w_flag_go_nxt;
  logic       w_flag_resume_nxt;
  logic       w_halted_nxt;
  logic       w_busy_nxt;

  logic       r_debug_req;
  logic       r_flag_go;
  logic       r_flag_resume;
  logic       r_halted;
  logic       r_resumeack;
  logic       r_cmd_busy;
  logic       r_cmd_done;
  logic [2:0] r_cmd_err;

  // Hart writes only count when the id field in the write data selects us.
  assign w_id_match      = (wdata_i[HartIdWidth-1:0] == HartIdWidth'(HartId));
  assign w_halted_vld    = wr_halted_en_i    & w_id_match;
  assign w_going_vld     = wr_going_en_i     & w_id_match;
  assign w_resuming_vld  = wr_resuming_en_i  & w_id_match;
  assign w_exception_vld = wr_exception_en_i & w_id_match;
  assign w_unused_wdata  = ^wdata_i[BusWidth-1:HartIdWidth];

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= RUNNING;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic plus the single-cycle events that ride on transitions.
  always_comb begin
    w_state_nxt    = r_state;
    w_cmd_done_nxt = 1'b0;
    w_ack_set      = 1'b0;
    w_ack_clr      = 1'b0;
    w_err_new      = 1'b0;
    w_err_val      = CmdErrNone;
    unique case (r_state)
      RUNNING: begin
        if (w_halted_vld) begin
          w_state_nxt = HALTED;
        end else if (haltreq_i) begin
          w_state_nxt = HALTING;
        end
      end
      HALTING: begin
        if (w_halted_vld) w_state_nxt = HALTED;
      end
      HALTED: begin
        // A command attempted while cmderr is set is dropped, which lets a
        // coincident resume request through.
        if (cmd_valid_i && (r_cmd_err == CmdErrNone)) begin
          w_state_nxt = CMD_GO;
        end else if (resumereq_i) begin
          w_state_nxt = RESUME;
          w_ack_clr   = 1'b1;
        end
      end
      CMD_GO: begin
        if (w_going_vld) w_state_nxt = CMD_EXEC;
      end
      CMD_EXEC: begin
        if (w_exception_vld) begin
          w_state_nxt    = HALTED;
          w_cmd_done_nxt = 1'b1;
          w_err_new      = 1'b1;
          w_err_val      = CmdErrException;
        end else if (w_halted_vld) begin
          w_state_nxt    = HALTED;
          w_cmd_done_nxt = 1'b1;
        end
      end
      RESUME: begin
        if (w_resuming_vld) begin
          w_state_nxt = RUNNING;
          w_ack_set   = 1'b1;
        end
      end
      default: w_state_nxt = RUNNING;
    endcase

    // Commands outside HALTED never change state; they only flag an error.
    if (cmd_valid_i && (r_cmd_err == CmdErrNone) && (r_state != HALTED)) begin
      w_err_new = 1'b1;
      w_err_val = ((r_state == CMD_GO) || (r_state == CMD_EXEC)) ? CmdErrBusy
                                                                  : CmdErrHaltResume;
    end
  end

  // Output decode from the upcoming state so the registered flags line up
  // with the state register.
  always_comb begin
    w_debug_req_nxt   = (w_state_nxt == HALTING);
    w_flag_go_nxt     = (w_state_nxt == CMD_GO);
    w_flag_resume_nxt = (w_state_nxt == RESUME);
    w_busy_nxt        = (w_state_nxt == CMD_GO) || (w_state_nxt == CMD_EXEC);
    w_halted_nxt      = (w_state_nxt == HALTED) || w_busy_nxt;
  end

  // Registered outputs and the sticky resumeack / cmderr status.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_debug_req   <= 1'b0;
      r_flag_go     <= 1'b0;
      r_flag_resume <= 1'b0;
      r_halted      <= 1'b0;
      r_resumeack   <= 1'b0;
      r_cmd_busy    <= 1'b0;
      r_cmd_done    <= 1'b0;
      r_cmd_err     <= CmdErrNone;
    end else begin
      r_debug_req   <= w_debug_req_nxt;
      r_flag_go     <= w_flag_go_nxt;
      r_flag_resume <= w_flag_resume_nxt;
      r_halted      <= w_halted_nxt;
      r_cmd_busy    <= w_busy_nxt;
      r_cmd_done    <= w_cmd_done_nxt;
      if (w_ack_set) begin
        r_resumeack <= 1'b1;
      end else if (w_ack_clr) begin
        r_resumeack <= 1'b0;
      end
      // First error sticks; a clear in the same cycle lets a new one in.
      if (w_err_new && ((r_cmd_err == CmdErrNone) || cmderr_clear_i)) begin
        r_cmd_err <= w_err_val;
      end else if (cmderr_clear_i) begin
        r_cmd_err <= CmdErrNone;
      end
    end
  end

  assign debug_req_o   = r_debug_req;
  assign flag_go_o     = r_flag_go;
  assign flag_resume_o = r_flag_resume;
  assign halted_o      = r_halted;
  assign resumeack_o   = r_resumeack;
  assign cmd_busy_o    = r_cmd_busy;
  assign cmd_done_o    = r_cmd_done;
  assign cmd_err_o     = r_cmd_err;

endmodule
